zbt_stream_fifo: RTL and testbench

//  Parametrised single-clock ZBT-backed stream FIFO for the parser: packs a byte stream into 32-bit

---
 rtl/zbt_pkg.sv | 12 +
 rtl/zbt_out_fifo.sv | 59 +++++
 rtl/zbt_stream_fifo.sv | 133 +++++++++++++
 tb/tb_zbt_stream_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_pkg.sv
// Shared ZBT bus widths and the slot encoding for the time-sliced ZBT port.
package zbt_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 32;

    typedef enum logic {
        SLOT_READ  = 1'b0,
        SLOT_WRITE = 1'b1
    } slot_e;

endpackage

// File: rtl/zbt_out_fifo.sv
// First-word fall-through FIFO holding words returned from the ZBT.
// Occupancy is exported so the top level can meter read requests against it.
module zbt_out_fifo
    import zbt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ZBT_DATA_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_idx;
    logic [AW-1:0]    r_rd_idx;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & ~i_flush;
    assign o_data  = r_mem[r_rd_idx];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_idx <= r_wr_idx + AW'(1);
            if (w_pop)  r_rd_idx <= r_rd_idx + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_idx] <= i_data;
    end

endmodule

// File: rtl/zbt_stream_fifo.sv
// Byte-stream FIFO spilling packed 32-bit words through a ZBT region, with alternating
// write/read slots, credit-metered reads and an on-chip fall-through output FIFO.
module zbt_stream_fifo
    import zbt_pkg::*;
#(
    parameter int                    ZBT_AW      = 17,
    parameter logic [ZBT_ADDR_W-1:0] REGION_BASE = 19'h60000,
    parameter int                    READ_LAT    = 2,
    parameter int                    OUT_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [ZBT_DATA_W-1:0] out_data_o,
    input  logic                  out_ready_i,
    input  logic                  zbt_access_i,
    output logic [ZBT_ADDR_W-1:0] zbt_address_o,
    output logic [ZBT_DATA_W-1:0] zbt_write_data_o,
    output logic                  zbt_write_en_o,
    input  logic [ZBT_DATA_W-1:0] zbt_read_data_i,
    output logic [ZBT_AW:0]       level_o,
    output logic                  empty_o
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_shift;
    logic                  r_stage_valid;
    logic [ZBT_DATA_W-1:0] r_stage_data;
    slot_e                 r_slot;
    logic [ZBT_AW:0]       r_wr_ptr;
    logic [ZBT_AW:0]       r_rd_ptr;
    logic [READ_LAT-1:0]   r_inflight;

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_zempty;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_push;
    logic [ZBT_AW-1:0]     w_slot_ptr;
    logic [CW-1:0]         w_out_cnt;
    logic [CW-1:0]         w_inflight_cnt;
    logic [CW:0]           w_credit_used;

    assign in_ready_o  = ~(r_stage_valid & (r_byte_cnt == 2'd3));
    assign w_accept    = in_valid_i & in_ready_o & ~flush_i;
    assign w_word_done = w_accept & (r_byte_cnt == 2'd3);

    assign w_zempty = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ZBT_AW] != r_rd_ptr[ZBT_AW]) &&
                      (r_wr_ptr[ZBT_AW-1:0] == r_rd_ptr[ZBT_AW-1:0]);

    // Reads already issued still own an output FIFO entry, so they count against the credit.
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + CW'(r_inflight[i]);
        end
    end

    assign w_credit_used = {1'b0, w_out_cnt} + {1'b0, w_inflight_cnt};

    assign w_wr_en = ~flush_i & (r_slot == SLOT_WRITE) & zbt_access_i & r_stage_valid & ~w_full;
    assign w_rd_en = ~flush_i & (r_slot == SLOT_READ) & zbt_access_i & ~w_zempty &
                     (w_credit_used < (CW+1)'(OUT_DEPTH));

    assign w_slot_ptr       = (r_slot == SLOT_WRITE) ? r_wr_ptr[ZBT_AW-1:0] : r_rd_ptr[ZBT_AW-1:0];
    assign zbt_address_o    = REGION_BASE | ZBT_ADDR_W'(w_slot_ptr);
    assign zbt_write_en_o   = w_wr_en;
    assign zbt_write_data_o = r_stage_data;

    assign level_o = r_wr_ptr - r_rd_ptr;
    assign empty_o = w_zempty & (w_out_cnt == '0) & (r_inflight == '0);
    assign w_push  = r_inflight[READ_LAT-1] & ~flush_i;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_byte_cnt    <= '0;
            r_stage_valid <= 1'b0;
            r_slot        <= SLOT_READ;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_inflight    <= '0;
        end else if (flush_i) begin
            r_byte_cnt    <= '0;
            r_stage_valid <= 1'b0;
            r_slot        <= SLOT_READ;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_inflight    <= '0;
        end else begin
            if (w_accept) r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_word_done)  r_stage_valid <= 1'b1;
            else if (w_wr_en) r_stage_valid <= 1'b0;
            r_slot <= (r_slot == SLOT_READ) ? SLOT_WRITE : SLOT_READ;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (ZBT_AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (ZBT_AW+1)'(1);
            r_inflight[0] <= w_rd_en;
            for (int i = 1; i < READ_LAT; i++) begin
                r_inflight[i] <= r_inflight[i-1];
            end
        end
    end

    // First byte ends up in the top byte of the packed word.
    always_ff @(posedge clock) begin
        if (w_accept)    r_shift      <= {r_shift[15:0], in_data_i};
        if (w_word_done) r_stage_data <= {r_shift, in_data_i};
    end

    zbt_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ZBT_DATA_W)
    ) u_out_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_data  (zbt_read_data_i),
        .i_pop   (out_ready_i),
        .o_data  (out_data_o),
        .o_valid (out_valid_o),
        .o_count (w_out_cnt)
    );

endmodule

// File: tb/tb_zbt_stream_fifo.sv
// Directed bench for zbt_stream_fifo with a 16-word region; a word-queue scoreboard
// follows every write and pop, and directed checks pin levels and literal words.
module tb_zbt_stream_fifo;

    localparam int          AW   = 4;
    localparam logic [18:0] BASE = 19'h60000;

    logic        clock = 1'b0;
    logic        resetn;
    logic        flush_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i;
    logic        zbt_access_i;
    logic [18:0] zbt_address_o;
    logic [31:0] zbt_write_data_o;
    logic        zbt_write_en_o;
    logic [31:0] zbt_read_data_i;
    logic [AW:0] level_o;
    logic        empty_o;

    always #5 clock = ~clock;

    zbt_stream_fifo #(
        .ZBT_AW      (AW),
        .REGION_BASE (BASE),
        .READ_LAT    (2),
        .OUT_DEPTH   (8)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .flush_i          (flush_i),
        .in_valid_i       (in_valid_i),
        .in_data_i        (in_data_i),
        .in_ready_o       (in_ready_o),
        .out_valid_o      (out_valid_o),
        .out_data_o       (out_data_o),
        .out_ready_i      (out_ready_i),
        .zbt_access_i     (zbt_access_i),
        .zbt_address_o    (zbt_address_o),
        .zbt_write_data_o (zbt_write_data_o),
        .zbt_write_en_o   (zbt_write_en_o),
        .zbt_read_data_i  (zbt_read_data_i),
        .level_o          (level_o),
        .empty_o          (empty_o)
    );

    // ZBT device: data for the address shown in a cycle returns two cycles later.
    logic [31:0] zmem [0:524287];
    logic [31:0] rpipe0, rpipe1;
    always @(posedge clock) begin
        if (zbt_write_en_o) zmem[zbt_address_o] <= zbt_write_data_o;
        rpipe0 <= zmem[zbt_address_o];
        rpipe1 <= rpipe0;
    end
    assign zbt_read_data_i = rpipe1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: complete words in input order since the last reset/flush.
    logic [31:0] exp_words [$];
    logic [31:0] pop_log [$];
    logic [31:0] partial;
    int          nbytes;
    int          wr_k, pop_k;
    int          wr_total  = 0;
    int          pops_total = 0;
    bit          slot_m;

    always @(negedge clock) begin
        if (!resetn || flush_i) begin
            exp_words.delete();
            nbytes = 0;
            wr_k   = 0;
            pop_k  = 0;
            slot_m = 1'b0;
        end else begin
            if (zbt_write_en_o) begin
                chk("write_slot", 32'(slot_m), 32'd1);
                chk("write_addr", 32'(zbt_address_o), 32'(BASE | 19'(wr_k % 16)));
                if (wr_k < exp_words.size()) begin
                    chk("write_data", zbt_write_data_o, exp_words[wr_k]);
                end else begin
                    total++; bad++;
                    $display("FAIL write_extra: write %0d with only %0d words packed", wr_k, exp_words.size());
                end
                wr_k++;
                wr_total++;
            end
            chk("level_bound", 32'(level_o > 5'd16), 32'd0);
            if (out_valid_o && out_ready_i) begin
                if (pop_k < wr_k) begin
                    chk("pop_data", out_data_o, exp_words[pop_k]);
                end else begin
                    total++; bad++;
                    $display("FAIL pop_unwritten: pop %0d with only %0d words written", pop_k, wr_k);
                end
                pop_log.push_back(out_data_o);
                pop_k++;
                pops_total++;
            end
            if (in_valid_i && in_ready_o) begin
                partial = {partial[23:0], in_data_i};
                nbytes++;
                if (nbytes == 4) begin
                    exp_words.push_back(partial);
                    nbytes = 0;
                end
            end
            slot_m = ~slot_m;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int limit, output bit ok);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_data_i  = b;
        while (!in_ready_o && n < limit) begin
            tick(1);
            n++;
        end
        ok = in_ready_o;
        if (ok) tick(1);
        in_valid_i = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] first, input int count, output int sent);
        bit ok;
        sent = 0;
        for (int i = 0; i < count; i++) begin
            send_byte(first + 8'(i), 30, ok);
            if (!ok) break;
            sent++;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_wen"}, 32'(zbt_write_en_o), 32'd0);
        chk({tag, "_level"}, 32'(level_o), 32'd0);
        chk({tag, "_empty"}, 32'(empty_o), 32'd1);
        chk({tag, "_addr"}, 32'(zbt_address_o), 32'(BASE));
    endtask

    int sent, p0, w0, n;

    initial begin
        resetn       = 1'b0;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_data_i    = 8'h00;
        out_ready_i  = 1'b1;
        zbt_access_i = 1'b1;
        tick(3);
        check_idle("reset");
        resetn = 1'b1;

        // Two words through the region.
        send_bytes(8'h01, 8, sent);
        chk("t1_sent", 32'(sent), 32'd8);
        tick(30);
        chk("t1_pops", 32'(pops_total), 32'd2);
        chk("t1_word0", pop_log[0], 32'h01020304);
        chk("t1_word1", pop_log[1], 32'h05060708);
        chk("t1_writes", 32'(wr_total), 32'd2);
        chk("t1_level", 32'(level_o), 32'd0);
        chk("t1_empty", 32'(empty_o), 32'd1);

        // Fill: 16 in region, 8 in output FIFO, 1 staged, 3 partial bytes.
        out_ready_i = 1'b0;
        p0 = pops_total;
        w0 = wr_total;
        send_bytes(8'h10, 200, sent);
        chk("t2_bytes_accepted", 32'(sent), 32'd103);
        tick(10);
        chk("t2_level_full", 32'(level_o), 32'd16);
        chk("t2_in_ready", 32'(in_ready_o), 32'd0);
        chk("t2_out_valid", 32'(out_valid_o), 32'd1);
        chk("t2_empty", 32'(empty_o), 32'd0);
        chk("t2_writes", 32'(wr_total - w0), 32'd24);
        chk("t2_no_pops", 32'(pops_total - p0), 32'd0);

        // Drain across the pointer wrap.
        out_ready_i = 1'b1;
        tick(120);
        chk("t3_pops", 32'(pops_total - p0), 32'd25);
        chk("t3_first", pop_log[p0], 32'h10111213);
        chk("t3_last", pop_log[p0 + 24], 32'h70717273);
        chk("t3_level", 32'(level_o), 32'd0);
        chk("t3_empty", 32'(empty_o), 32'd1);

        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;

        // Read credit: exactly OUT_DEPTH reads with the consumer stalled.
        out_ready_i = 1'b0;
        p0 = pops_total;
        send_bytes(8'h80, 48, sent);
        chk("t4_sent", 32'(sent), 32'd48);
        tick(40);
        chk("t4_level_after_credit", 32'(level_o), 32'd4);
        chk("t4_out_valid", 32'(out_valid_o), 32'd1);
        chk("t4_no_pops", 32'(pops_total - p0), 32'd0);
        out_ready_i = 1'b1;
        tick(1);
        out_ready_i = 1'b0;
        tick(20);
        chk("t4_one_more_read", 32'(level_o), 32'd3);
        chk("t4_one_pop", 32'(pops_total - p0), 32'd1);
        chk("t4_pop_word", pop_log[p0], 32'h80818283);
        out_ready_i = 1'b1;
        tick(60);
        chk("t4_all_pops", 32'(pops_total - p0), 32'd12);
        chk("t4_empty", 32'(empty_o), 32'd1);

        // Flush with reads running and a partial word packed.
        out_ready_i = 1'b0;
        send_bytes(8'hC0, 51, sent);
        chk("t5_sent", 32'(sent), 32'd51);
        tick(30);
        chk("t5_level_before", 32'(level_o), 32'd4);
        out_ready_i = 1'b1;
        tick(3);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        check_idle("t5_flush");
        p0 = pops_total;
        tick(6);
        chk("t5_late_data_ignored", 32'(pops_total - p0), 32'd0);
        chk("t5_out_valid_late", 32'(out_valid_o), 32'd0);
        send_bytes(8'hA0, 4, sent);
        tick(20);
        chk("t5_one_pop", 32'(pops_total - p0), 32'd1);
        chk("t5_clean_word", pop_log[pop_log.size() - 1], 32'hA0A1A2A3);
        chk("t5_empty", 32'(empty_o), 32'd1);

        // Asynchronous reset while a write strobe is active.
        send_bytes(8'h11, 4, sent);
        n = 0;
        while (!zbt_write_en_o && n < 10) begin
            tick(1);
            n++;
        end
        chk("t6_wen_seen", 32'(zbt_write_en_o), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_idle("t6_async");
        tick(2);
        resetn = 1'b1;
        w0 = wr_total;
        tick(10);
        chk("t6_no_write_after", 32'(wr_total - w0), 32'd0);
        chk("t6_empty", 32'(empty_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
